// File: rtl/branch_resolve.sv
// ID-stage conditional branch resolver: computes the real outcome, sends one predictor
// update beat, and on a mispredict redirects pc_reg and holds a flush. Optional stats: BR_STATS_EN.
module branch_resolve #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned HIST_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [31:0]       id_pc,
  input  logic [2:0]        id_funct3,
  input  logic [31:0]       id_rs1_data,
  input  logic [31:0]       id_rs2_data,
  input  logic [31:0]       id_imm,
  input  logic              id_pdt_res,
  input  logic              id_which_pdt,
  input  logic [HIST_W-1:0] id_history,
  output logic              upd_valid,
  output logic              upd_taken,
  output logic              upd_pdt_true,
  output logic              upd_which,
  output logic [31:0]       upd_pc,
  output logic [HIST_W-1:0] upd_history,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic              flush_o,
`ifdef BR_STATS_EN
  input  logic              stat_clr,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts,
`endif
  output logic              illegal_o
);

  typedef enum logic {IDLE, FLUSH} state_e;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush
    $error("FLUSH_CYCLES must be within 1..15");
  end

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                upd_valid_q, upd_valid_d;
  logic                upd_taken_q, upd_taken_d;
  logic                upd_true_q, upd_true_d;
  logic                upd_which_q, upd_which_d;
  logic [31:0]         upd_pc_q, upd_pc_d;
  logic [HIST_W-1:0]   upd_hist_q, upd_hist_d;
  logic                redir_valid_q, redir_valid_d;
  logic [31:0]         redir_pc_q, redir_pc_d;
  logic                illegal_q, illegal_d;

  logic                accept, taken, illegal, mispredict;
  logic [31:0]         next_pc;

  // Outcome compare; reserved funct3 encodings resolve as not-taken and flag illegal.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    unique case (id_funct3)
      3'b000:  taken = (id_rs1_data == id_rs2_data);
      3'b001:  taken = (id_rs1_data != id_rs2_data);
      3'b100:  taken = ($signed(id_rs1_data) <  $signed(id_rs2_data));
      3'b101:  taken = ($signed(id_rs1_data) >= $signed(id_rs2_data));
      3'b110:  taken = (id_rs1_data <  id_rs2_data);
      3'b111:  taken = (id_rs1_data >= id_rs2_data);
      default: illegal = 1'b1;
    endcase
  end

  assign id_ready   = (state_q == IDLE);
  assign accept     = id_valid && id_ready;
  assign mispredict = (taken != id_pdt_res);
  assign next_pc    = taken ? (id_pc + id_imm) : (id_pc + 32'd4);

  // Flush FSM: the counter holds remaining flush cycles minus one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept && mispredict) begin
          state_d = FLUSH;
          cnt_d   = CNT_LOAD;
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Update/redirect beat; data fields hold their last value between beats.
  always_comb begin
    upd_valid_d   = accept;
    upd_taken_d   = upd_taken_q;
    upd_true_d    = upd_true_q;
    upd_which_d   = upd_which_q;
    upd_pc_d      = upd_pc_q;
    upd_hist_d    = upd_hist_q;
    redir_valid_d = accept && mispredict;
    redir_pc_d    = redir_pc_q;
    illegal_d     = accept && illegal;
    if (accept) begin
      upd_taken_d = taken;
      upd_true_d  = !mispredict;
      upd_which_d = id_which_pdt;
      upd_pc_d    = id_pc;
      upd_hist_d  = id_history;
      if (mispredict) redir_pc_d = next_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      upd_valid_q   <= 1'b0;
      upd_taken_q   <= 1'b0;
      upd_true_q    <= 1'b0;
      upd_which_q   <= 1'b0;
      upd_pc_q      <= 32'd0;
      upd_hist_q    <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= 32'd0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      upd_valid_q   <= upd_valid_d;
      upd_taken_q   <= upd_taken_d;
      upd_true_q    <= upd_true_d;
      upd_which_q   <= upd_which_d;
      upd_pc_q      <= upd_pc_d;
      upd_hist_q    <= upd_hist_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      illegal_q     <= illegal_d;
    end
  end

  assign upd_valid      = upd_valid_q;
  assign upd_taken      = upd_taken_q;
  assign upd_pdt_true   = upd_true_q;
  assign upd_which      = upd_which_q;
  assign upd_pc         = upd_pc_q;
  assign upd_history    = upd_hist_q;
  assign redirect_valid = redir_valid_q;
  assign redirect_pc    = redir_pc_q;
  assign flush_o        = (state_q == FLUSH);
  assign illegal_o      = illegal_q;

`ifdef BR_STATS_EN
  logic [31:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;

  // Counters follow the emitted beats, so they tick the cycle after accept.
  always_comb begin
    stat_br_d = stat_br_q + {31'd0, upd_valid_q};
    stat_mp_d = stat_mp_q + {31'd0, redir_valid_q};
    if (stat_clr) begin
      stat_br_d = 32'd0;
      stat_mp_d = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_br_q <= 32'd0;
      stat_mp_q <= 32'd0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- ID-stage branch resolution unit. Consumes a decoded conditional branch plus the prediction metadata captured at fetch (predicted direction, chosen sub-predictor, global history snapshot), and computes the real outcome.
- Emits a one-cycle update beat back to the branch predictor.
- On a misprediction, emits a redirect PC to pc_reg and holds a pipeline flush for a fixed number of cycles.
- Sits between the decode/register-read stage and the predictor and pc_reg.

Parameters:
- FLUSH_CYCLES, 2, cycles flush_o stays high after a mispredict (legal range 1..15)
- HIST_W, 10, width of the global history snapshot

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- id_valid  in  1  a branch is presented this cycle
- id_ready  out  1  block can accept a branch this cycle
- id_pc  in  32  PC of the branch
- id_funct3  in  3  branch funct3
- id_rs1_data  in  32  operand 1
- id_rs2_data  in  32  operand 2
- id_imm  in  32  sign-extended B-type offset (bit 0 = 0)
- id_pdt_res  in  1  predicted direction (1 = taken)
- id_which_pdt  in  1  sub-predictor used (0 = local, 1 = global)
- id_history  in  HIST_W  history snapshot taken at prediction time
- upd_valid  out  1  predictor update strobe, one cycle
- upd_taken  out  1  actual direction
- upd_pdt_true  out  1  prediction correct
- upd_which  out  1  echo of id_which_pdt
- upd_pc  out  32  echo of id_pc
- upd_history  out  HIST_W  echo of id_history
- redirect_valid  out  1  one-cycle pulse: pc_reg must load redirect_pc
- redirect_pc  out  32  correct next PC
- flush_o  out  1  squash IF/ID contents
- illegal_o  out  1  one-cycle pulse: funct3 was 010 or 011

Behaviour:
- Reset:
  - All outputs are 0, id_ready is 1, and the FSM is in IDLE.
  - Reset takes effect immediately, including mid-flush. An in-flight update or redirect is discarded, not replayed.
- Accept: a branch is accepted on the rising edge when id_valid && id_ready. Inputs are sampled only at that edge.
- Outcome compare by funct3:
  - 000 BEQ (rs1 == rs2)
  - 001 BNE (!=)
  - 100 BLT (signed <)
  - 101 BGE (signed >=)
  - 110 BLTU (unsigned <)
  - 111 BGEU (unsigned >=)
  - 010 or 011: taken = 0 and illegal_o pulses; the update is still issued.
- Next PC:
  - Taken target = id_pc + id_imm, modulo 2^32 (wraps silently).
  - Not taken = id_pc + 4, modulo 2^32.
- Latency:
  - All upd_* and illegal_o are registered and valid exactly 1 cycle after accept. upd_valid is high for exactly that cycle.
  - upd_pdt_true = (taken == id_pdt_res).
  - upd_* data fields hold their last value while upd_valid = 0.
- Mispredict (upd_pdt_true = 0), in the same cycle as upd_valid:
  - redirect_valid pulses for 1 cycle, with redirect_pc = actual next PC.
  - flush_o goes high and the FSM enters FLUSH.
- FSM:
  - IDLE: id_ready = 1. On accept with mispredict -> FLUSH; load the counter with FLUSH_CYCLES-1. On a correct accept, stay in IDLE; back-to-back accepts every cycle are legal.
  - FLUSH: flush_o = 1 and id_ready = 0; id_valid is ignored. The counter decrements each cycle. At 0, return to IDLE next cycle. flush_o is therefore high for exactly FLUSH_CYCLES cycles.
- Simultaneous events:
  - In the cycle a mispredict update is emitted, id_ready is already 0, so a branch presented in that cycle is not accepted.
  - A correct-prediction update and a new accept may coincide.
- redirect_valid never asserts while the FSM is in FLUSH, except for the initial pulse.

Optional Feature:
- Macro BR_STATS_EN.
- Defined:
  - Adds outputs stat_branches[31:0] and stat_mispredicts[31:0], and input stat_clr.
  - Counters increment on each upd_valid and each mispredict respectively, and wrap at 2^32.
  - stat_clr zeroes both counters synchronously and has priority over increment.
  - Counters reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- BEQ: pc=0x100, rs1=rs2=5, imm=0x20, pdt_res=1 -> next cycle upd_valid=1, upd_taken=1, upd_pdt_true=1, no redirect, flush_o=0.
- BLT: rs1=0xFFFFFFFF, rs2=1, pc=0x200, imm=-8, pdt_res=0 -> upd_taken=1, upd_pdt_true=0, redirect_valid=1, redirect_pc=0x1F8, flush_o high exactly 2 cycles, id_ready=0 for those cycles.
- BLTU with the same operands, pdt_res=1 -> upd_taken=0, redirect_pc=0x204, mispredict flush.
- Wrap: pc=0xFFFFFFFC, not taken, predicted taken -> redirect_pc=0x00000000.
- funct3=010, pdt_res=0 -> illegal_o=1, upd_taken=0, upd_pdt_true=1; id_valid held high during FLUSH after a mispredict is not accepted (no extra upd_valid).
- Assert rst=0 during the 2nd flush cycle -> flush_o, redirect_valid and upd_valid drop to 0 immediately and id_ready=1; with BR_STATS_EN, the counters read 0.
